// File: rtl/beta_razor_ctrl_if.sv
// Handshake and data bundle between the razor beta controller, the beta pipe and the beta store.
interface beta_razor_ctrl_if #(
    parameter int M  = 6,
    parameter int AW = 5,
    parameter int EW = 8
);
    logic              start;
    logic [AW-1:0]     win_len;
    logic [7*M-1:0]    init_beta;
    logic [AW-1:0]     bm_addr;
    logic              issue;
    logic [7*M-1:0]    beta_to_pipe;
    logic [7*M-1:0]    beta_from_pipe;
    logic              Error_current_Beta;
    logic              bw_en;
    logic [AW-1:0]     bw_addr;
    logic [7*M-1:0]    bw_data;
    logic              busy;
    logic              done;
    logic              fail;
    logic [EW-1:0]     err_count;

    modport master (
        input  start, win_len, init_beta, beta_from_pipe, Error_current_Beta,
        output bm_addr, issue, beta_to_pipe, bw_en, bw_addr, bw_data,
        busy, done, fail, err_count
    );

    modport slave (
        output start, win_len, init_beta, beta_from_pipe, Error_current_Beta,
        input  bm_addr, issue, beta_to_pipe, bw_en, bw_addr, bw_data,
        busy, done, fail, err_count
    );
endinterface

// File: rtl/beta_razor_ctrl.sv
// Sequences one backward beta window through a razor-checked pipe stage, replaying failed sections.
// Latency: L sections issue in cycles 1..L, commit one cycle later, done in cycle L+2; +2 per razor error.
// No backpressure: one section per cycle; a razor error squashes the in-flight issue and replays.
module beta_razor_ctrl #(
    parameter int M         = 6,
    parameter int AW        = 5,
    parameter int EW        = 8,
    parameter int MAX_RETRY = 2
) (
    input  logic              Clock,
    input  logic              nReset,
    beta_razor_ctrl_if.master bus
);
    localparam int BW = 7 * M;
    localparam int RW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
    localparam logic [RW-1:0] MAX_R = RW'(MAX_RETRY);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_RECOVER, S_DONE} state_t;

    state_t         state_q, state_d;
    logic [AW-1:0]  sec_q, sec_d;
    logic           sec_vld_q, sec_vld_d;
    logic           first_q, first_d;
    logic [AW-1:0]  pend_q, pend_d;
    logic           pend_vld_q, pend_vld_d;
    logic [AW-1:0]  replay_q, replay_d;
    logic [AW-1:0]  last_q, last_d;
    logic [BW-1:0]  good_beta_q, good_beta_d;
    logic [RW-1:0]  retry_q, retry_d;
    logic           fail_q, fail_d;
    logic [EW-1:0]  err_cnt_q, err_cnt_d;

    logic           issue, bw_en, busy, done, val_err;
    logic [AW-1:0]  bm_addr, bw_addr;
    logic [BW-1:0]  beta_to_pipe, bw_data;

    always_comb begin
        state_d      = state_q;
        sec_d        = sec_q;
        sec_vld_d    = sec_vld_q;
        first_d      = first_q;
        pend_d       = pend_q;
        pend_vld_d   = pend_vld_q;
        replay_d     = replay_q;
        last_d       = last_q;
        good_beta_d  = good_beta_q;
        retry_d      = retry_q;
        fail_d       = fail_q;
        err_cnt_d    = err_cnt_q;
        issue        = 1'b0;
        bm_addr      = '0;
        beta_to_pipe = '0;
        bw_en        = 1'b0;
        bw_addr      = '0;
        bw_data      = '0;
        busy         = 1'b0;
        done         = 1'b0;
        val_err      = pend_vld_q && bus.Error_current_Beta;

        case (state_q)
            S_IDLE: begin
                if (bus.start && (bus.win_len != '0)) begin
                    state_d    = S_RUN;
                    sec_d      = bus.win_len - 1'b1;
                    last_d     = bus.win_len - 1'b1;
                    sec_vld_d  = 1'b1;
                    first_d    = 1'b1;
                    pend_vld_d = 1'b0;
                    fail_d     = 1'b0;
                    err_cnt_d  = '0;
                    retry_d    = '0;
                end
            end
            S_RUN: begin
                busy = 1'b1;
                if (pend_vld_q && !bus.Error_current_Beta) begin
                    bw_en       = 1'b1;
                    bw_addr     = pend_q;
                    bw_data     = bus.beta_from_pipe;
                    good_beta_d = bus.beta_from_pipe;
                    retry_d     = '0;
                end
                // A failed validation squashes the section that would forward the bad beta.
                if (sec_vld_q && !val_err) begin
                    issue        = 1'b1;
                    bm_addr      = sec_q;
                    beta_to_pipe = first_q ? bus.init_beta : bus.beta_from_pipe;
                    sec_d        = sec_q - 1'b1;
                    sec_vld_d    = (sec_q != '0);
                    first_d      = 1'b0;
                    pend_d       = sec_q;
                    pend_vld_d   = 1'b1;
                end else begin
                    pend_vld_d = 1'b0;
                end
                if (val_err) begin
                    if (err_cnt_q != {EW{1'b1}})
                        err_cnt_d = err_cnt_q + 1'b1;
                    if (retry_q == MAX_R) begin
                        fail_d  = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        retry_d  = retry_q + 1'b1;
                        replay_d = pend_q;
                        state_d  = S_RECOVER;
                    end
                end else if (!sec_vld_q) begin
                    state_d = S_DONE;
                end
            end
            S_RECOVER: begin
                busy         = 1'b1;
                issue        = 1'b1;
                bm_addr      = replay_q;
                beta_to_pipe = (replay_q == last_q) ? bus.init_beta : good_beta_q;
                pend_d       = replay_q;
                pend_vld_d   = 1'b1;
                sec_d        = replay_q - 1'b1;
                sec_vld_d    = (replay_q != '0);
                first_d      = 1'b0;
                state_d      = S_RUN;
            end
            S_DONE: begin
                done       = 1'b1;
                pend_vld_d = 1'b0;
                sec_vld_d  = 1'b0;
                state_d    = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            state_q     <= S_IDLE;
            sec_q       <= '0;
            sec_vld_q   <= 1'b0;
            first_q     <= 1'b0;
            pend_q      <= '0;
            pend_vld_q  <= 1'b0;
            replay_q    <= '0;
            last_q      <= '0;
            good_beta_q <= '0;
            retry_q     <= '0;
            fail_q      <= 1'b0;
            err_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            sec_q       <= sec_d;
            sec_vld_q   <= sec_vld_d;
            first_q     <= first_d;
            pend_q      <= pend_d;
            pend_vld_q  <= pend_vld_d;
            replay_q    <= replay_d;
            last_q      <= last_d;
            good_beta_q <= good_beta_d;
            retry_q     <= retry_d;
            fail_q      <= fail_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign bus.issue        = issue;
    assign bus.bm_addr      = bm_addr;
    assign bus.beta_to_pipe = beta_to_pipe;
    assign bus.bw_en        = bw_en;
    assign bus.bw_addr      = bw_addr;
    assign bus.bw_data      = bw_data;
    assign bus.busy         = busy;
    assign bus.done         = done;
    assign bus.fail         = fail_q;
    assign bus.err_count    = err_cnt_q;
endmodule

// File: tb/tb_beta_razor_ctrl.sv
// Bench for beta_razor_ctrl: behavioural beta pipe, commit scoreboard and per-scenario timing checks.
module tb_beta_razor_ctrl;
    localparam int M  = 6;
    localparam int AW = 5;
    localparam int EW = 8;
    localparam int BW = 7 * M;
    localparam logic [BW-1:0] CORRUPT = {7{6'b101101}};

    typedef struct packed {
        logic [AW-1:0] a;
        logic [BW-1:0] d;
    } exp_t;

    logic Clock = 1'b0;
    logic nReset;
    int   checks = 0;
    int   errors = 0;
    exp_t sbq[$];
    logic [BW-1:0] pipe_q;

    always #5 Clock = ~Clock;

    beta_razor_ctrl_if #(.M(M), .AW(AW), .EW(EW)) ifa ();
    beta_razor_ctrl_if #(.M(M), .AW(AW), .EW(2))  ifb ();

    beta_razor_ctrl #(.M(M), .AW(AW), .EW(EW), .MAX_RETRY(2)) dut (
        .Clock(Clock), .nReset(nReset), .bus(ifa)
    );
    beta_razor_ctrl #(.M(M), .AW(AW), .EW(2), .MAX_RETRY(7)) dut_sat (
        .Clock(Clock), .nReset(nReset), .bus(ifb)
    );

    // Stand-in for the beta pipe stage; a razor error corrupts the value seen by the controller.
    function automatic logic [BW-1:0] pipe_f(input logic [BW-1:0] b, input logic [AW-1:0] a);
        logic [BW-1:0] r;
        for (int i = 0; i < 7; i++)
            r[i*M +: M] = b[((i + 1) % 7)*M +: M] + M'(a) + M'(i * 3 + 1);
        return r;
    endfunction

    always @(posedge Clock or negedge nReset) begin
        if (!nReset) pipe_q <= '0;
        else if (ifa.issue) pipe_q <= pipe_f(ifa.beta_to_pipe, ifa.bm_addr);
    end
    assign ifa.beta_from_pipe = pipe_q ^ (ifa.Error_current_Beta ? CORRUPT : '0);
    assign ifb.beta_from_pipe = '0;

    task automatic push_window(input int len, input logic [BW-1:0] init);
        logic [BW-1:0] b;
        b = init;
        for (int k = len - 1; k >= 0; k--) begin
            b = pipe_f(b, AW'(k));
            sbq.push_back({AW'(k), b});
        end
    endtask

    task automatic pulse_start(input int len);
        ifa.start   = 1'b1;
        ifa.win_len = AW'(len);
        @(posedge Clock); #1;
        ifa.start   = 1'b0;
    endtask

    task automatic test_reset;
        nReset = 1'b0;
        ifa.start = 1'b0; ifa.win_len = '0; ifa.init_beta = '0; ifa.Error_current_Beta = 1'b0;
        ifb.start = 1'b0; ifb.win_len = '0; ifb.init_beta = '0; ifb.Error_current_Beta = 1'b0;
        #12;
        checks++;
        if ({ifa.busy, ifa.done, ifa.issue, ifa.bw_en, ifa.fail} !== 5'b0) begin
            errors++; $display("FAIL reset_flags got %b exp 00000", {ifa.busy, ifa.done, ifa.issue, ifa.bw_en, ifa.fail});
        end
        checks++;
        if (ifa.err_count !== '0) begin errors++; $display("FAIL reset_errcnt got %0d exp 0", ifa.err_count); end
        checks++;
        if ({ifa.bm_addr, ifa.beta_to_pipe, ifa.bw_addr, ifa.bw_data} !== '0) begin
            errors++; $display("FAIL reset_buses got %h/%h exp 0", ifa.bm_addr, ifa.beta_to_pipe);
        end
        @(negedge Clock); nReset = 1'b1;
        @(posedge Clock); #1;
    endtask

    task automatic test_nominal;
        logic [BW-1:0] init;
        logic ei, eb, ed, ey; logic [AW-1:0] ea; exp_t e;
        init = {$urandom, $urandom};
        ifa.init_beta = init;
        push_window(4, init);
        pulse_start(4);
        for (int c = 1; c <= 6; c++) begin
            @(negedge Clock);
            ei = (c <= 4); ea = ei ? AW'(4 - c) : '0;
            eb = (c >= 2 && c <= 5); ed = (c == 6); ey = (c <= 5);
            checks++;
            if ({ifa.issue, (ifa.issue ? ifa.bm_addr : AW'(0)), ifa.bw_en, ifa.done, ifa.busy} !== {ei, ea, eb, ed, ey}) begin
                errors++; $display("FAIL nom_timing c%0d got %b/%0d/%b%b%b exp %b/%0d/%b%b%b", c,
                    ifa.issue, ifa.bm_addr, ifa.bw_en, ifa.done, ifa.busy, ei, ea, eb, ed, ey);
            end
            if (c == 1) begin
                checks++;
                if (ifa.beta_to_pipe !== init) begin errors++; $display("FAIL nom_init_beta got %h exp %h", ifa.beta_to_pipe, init); end
            end
            if (ifa.bw_en) begin
                e = (sbq.size() != 0) ? sbq.pop_front() : '1;
                checks++;
                if ({ifa.bw_addr, ifa.bw_data} !== e) begin errors++; $display("FAIL nom_commit c%0d got %0d/%h exp %0d/%h", c, ifa.bw_addr, ifa.bw_data, e.a, e.d); end
            end
            @(posedge Clock); #1;
        end
        checks++;
        if (sbq.size() != 0) begin errors++; $display("FAIL nom_left got %0d exp 0", sbq.size()); sbq.delete(); end
    endtask

    task automatic test_error_mid;
        logic [BW-1:0] init, b3; exp_t e;
        init = {$urandom, $urandom};
        b3 = pipe_f(init, AW'(3));
        ifa.init_beta = init;
        push_window(4, init);
        pulse_start(4);
        for (int c = 1; c <= 8; c++) begin
            ifa.Error_current_Beta = (c == 3);
            @(negedge Clock);
            checks++;
            if ({ifa.bw_en, ifa.done} !== {(c == 2 || (c >= 5 && c <= 7)), (c == 8)}) begin
                errors++; $display("FAIL mid_timing c%0d got bw_en=%b done=%b", c, ifa.bw_en, ifa.done);
            end
            if (c == 4) begin
                checks++;
                if ({ifa.issue, ifa.bm_addr, ifa.beta_to_pipe} !== {1'b1, AW'(2), b3}) begin
                    errors++; $display("FAIL mid_recover got %b/%0d/%h exp 1/2/%h", ifa.issue, ifa.bm_addr, ifa.beta_to_pipe, b3);
                end
            end
            if (ifa.bw_en) begin
                e = (sbq.size() != 0) ? sbq.pop_front() : '1;
                checks++;
                if ({ifa.bw_addr, ifa.bw_data} !== e) begin errors++; $display("FAIL mid_commit c%0d got %0d/%h exp %0d/%h", c, ifa.bw_addr, ifa.bw_data, e.a, e.d); end
            end
            @(posedge Clock); #1;
        end
        ifa.Error_current_Beta = 1'b0;
        checks++;
        if (ifa.err_count !== 8'd1) begin errors++; $display("FAIL mid_errcnt got %0d exp 1", ifa.err_count); end
        checks++;
        if (sbq.size() != 0) begin errors++; $display("FAIL mid_left got %0d exp 0", sbq.size()); sbq.delete(); end
    endtask

    task automatic test_error_first;
        logic [BW-1:0] init; exp_t e;
        init = {$urandom, $urandom};
        ifa.init_beta = init;
        push_window(3, init);
        pulse_start(3);
        for (int c = 1; c <= 7; c++) begin
            ifa.Error_current_Beta = (c == 2);
            @(negedge Clock);
            checks++;
            if ({ifa.bw_en, ifa.done} !== {(c >= 4 && c <= 6), (c == 7)}) begin
                errors++; $display("FAIL first_timing c%0d got bw_en=%b done=%b", c, ifa.bw_en, ifa.done);
            end
            if (c == 3) begin
                checks++;
                if ({ifa.issue, ifa.bm_addr, ifa.beta_to_pipe} !== {1'b1, AW'(2), init}) begin
                    errors++; $display("FAIL first_replay got %b/%0d/%h exp 1/2/%h", ifa.issue, ifa.bm_addr, ifa.beta_to_pipe, init);
                end
            end
            if (ifa.bw_en) begin
                e = (sbq.size() != 0) ? sbq.pop_front() : '1;
                checks++;
                if ({ifa.bw_addr, ifa.bw_data} !== e) begin errors++; $display("FAIL first_commit c%0d got %0d/%h exp %0d/%h", c, ifa.bw_addr, ifa.bw_data, e.a, e.d); end
            end
            @(posedge Clock); #1;
        end
        ifa.Error_current_Beta = 1'b0;
        checks++;
        if (sbq.size() != 0) begin errors++; $display("FAIL first_left got %0d exp 0", sbq.size()); sbq.delete(); end
    endtask

    task automatic test_abort;
        logic [BW-1:0] init; exp_t e;
        init = {$urandom, $urandom};
        ifa.init_beta = init;
        push_window(3, init);
        pulse_start(3);
        for (int c = 1; c <= 9; c++) begin
            ifa.Error_current_Beta = (c == 3 || c == 5 || c == 7);
            @(negedge Clock);
            checks++;
            if ({ifa.bw_en, ifa.done} !== {(c == 2), (c == 8)}) begin
                errors++; $display("FAIL abort_timing c%0d got bw_en=%b done=%b", c, ifa.bw_en, ifa.done);
            end
            if (c == 4 || c == 6) begin
                checks++;
                if ({ifa.issue, ifa.bm_addr} !== {1'b1, AW'(1)}) begin errors++; $display("FAIL abort_replay c%0d got %b/%0d exp 1/1", c, ifa.issue, ifa.bm_addr); end
            end
            if (c >= 8) begin
                checks++;
                if ({ifa.fail, ifa.busy} !== 2'b10) begin errors++; $display("FAIL abort_fail c%0d got fail=%b busy=%b exp 1/0", c, ifa.fail, ifa.busy); end
            end
            if (ifa.bw_en) begin
                e = (sbq.size() != 0) ? sbq.pop_front() : '1;
                checks++;
                if ({ifa.bw_addr, ifa.bw_data} !== e) begin errors++; $display("FAIL abort_commit c%0d got %0d/%h exp %0d/%h", c, ifa.bw_addr, ifa.bw_data, e.a, e.d); end
            end
            @(posedge Clock); #1;
        end
        ifa.Error_current_Beta = 1'b0;
        checks++;
        if (ifa.err_count !== 8'd3) begin errors++; $display("FAIL abort_errcnt got %0d exp 3", ifa.err_count); end
        checks++;
        if (sbq.size() != 2) begin errors++; $display("FAIL abort_unwritten got %0d exp 2", sbq.size()); end
        sbq.delete();
    endtask

    task automatic test_win1;
        logic [BW-1:0] init; exp_t e;
        init = {$urandom, $urandom};
        ifa.init_beta = init;
        push_window(1, init);
        pulse_start(1);
        for (int c = 1; c <= 3; c++) begin
            @(negedge Clock);
            checks++;
            if ({ifa.issue, ifa.bm_addr, ifa.bw_en, ifa.done} !== {(c == 1), AW'(0), (c == 2), (c == 3)}) begin
                errors++; $display("FAIL win1_timing c%0d got %b/%0d/%b/%b", c, ifa.issue, ifa.bm_addr, ifa.bw_en, ifa.done);
            end
            if (c == 1) begin
                checks++;
                if ({ifa.fail, ifa.err_count} !== '0) begin errors++; $display("FAIL win1_cleared got fail=%b err=%0d exp 0/0", ifa.fail, ifa.err_count); end
            end
            if (ifa.bw_en) begin
                e = (sbq.size() != 0) ? sbq.pop_front() : '1;
                checks++;
                if ({ifa.bw_addr, ifa.bw_data} !== e) begin errors++; $display("FAIL win1_commit got %0d/%h exp %0d/%h", ifa.bw_addr, ifa.bw_data, e.a, e.d); end
            end
            @(posedge Clock); #1;
        end
    endtask

    task automatic test_zero_len;
        pulse_start(0);
        for (int c = 1; c <= 3; c++) begin
            @(negedge Clock);
            checks++;
            if ({ifa.busy, ifa.issue, ifa.bw_en, ifa.done} !== 4'b0) begin
                errors++; $display("FAIL zero_len c%0d got %b%b%b%b exp 0000", c, ifa.busy, ifa.issue, ifa.bw_en, ifa.done);
            end
            @(posedge Clock); #1;
        end
    endtask

    task automatic test_async_reset;
        logic [BW-1:0] init; exp_t e;
        init = {$urandom, $urandom};
        ifa.init_beta = init;
        push_window(4, init);
        pulse_start(4);
        @(posedge Clock); #1;
        ifa.Error_current_Beta = 1'b1;
        @(posedge Clock); #1;
        ifa.Error_current_Beta = 1'b0;
        checks++;
        if ({ifa.busy, ifa.err_count} !== {1'b1, 8'd1}) begin errors++; $display("FAIL arst_pre got busy=%b err=%0d exp 1/1", ifa.busy, ifa.err_count); end
        #1 nReset = 1'b0;
        #1;
        checks++;
        if ({ifa.busy, ifa.done, ifa.issue, ifa.bw_en, ifa.fail} !== 5'b0) begin
            errors++; $display("FAIL arst_flags got %b exp 00000", {ifa.busy, ifa.done, ifa.issue, ifa.bw_en, ifa.fail});
        end
        checks++;
        if ({ifa.err_count, ifa.bm_addr, ifa.beta_to_pipe, ifa.bw_data} !== '0) begin
            errors++; $display("FAIL arst_buses got err=%0d addr=%0d beta=%h", ifa.err_count, ifa.bm_addr, ifa.beta_to_pipe);
        end
        @(posedge Clock); #1;
        checks++;
        if (ifa.bw_en !== 1'b0) begin errors++; $display("FAIL arst_no_commit got %b exp 0", ifa.bw_en); end
        sbq.delete();
        @(negedge Clock); nReset = 1'b1;
        @(posedge Clock); #1;
        push_window(2, init);
        pulse_start(2);
        for (int c = 1; c <= 4; c++) begin
            @(negedge Clock);
            checks++;
            if ({ifa.bw_en, ifa.done, ifa.err_count} !== {(c == 2 || c == 3), (c == 4), 8'd0}) begin
                errors++; $display("FAIL arst_fresh c%0d got bw_en=%b done=%b err=%0d", c, ifa.bw_en, ifa.done, ifa.err_count);
            end
            if (ifa.bw_en) begin
                e = (sbq.size() != 0) ? sbq.pop_front() : '1;
                checks++;
                if ({ifa.bw_addr, ifa.bw_data} !== e) begin errors++; $display("FAIL arst_commit c%0d got %0d/%h exp %0d/%h", c, ifa.bw_addr, ifa.bw_data, e.a, e.d); end
            end
            @(posedge Clock); #1;
        end
        checks++;
        if (sbq.size() != 0) begin errors++; $display("FAIL arst_left got %0d exp 0", sbq.size()); sbq.delete(); end
    endtask

    task automatic test_saturate;
        bit seen;
        ifb.init_beta = {$urandom, $urandom};
        ifb.start = 1'b1; ifb.win_len = AW'(2);
        @(posedge Clock); #1;
        ifb.start = 1'b0;
        for (int c = 1; c <= 11; c++) begin
            ifb.Error_current_Beta = (c == 2 || c == 4 || c == 6 || c == 8 || c == 10);
            @(negedge Clock);
            if (c == 7 || c == 11) begin
                checks++;
                if (ifb.err_count !== 2'd3) begin errors++; $display("FAIL sat_errcnt c%0d got %0d exp 3", c, ifb.err_count); end
            end
            @(posedge Clock); #1;
        end
        ifb.Error_current_Beta = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(negedge Clock);
            if (ifb.done) seen = 1'b1;
            @(posedge Clock); #1;
        end
        checks++;
        if (!seen) begin errors++; $display("FAIL sat_done got no done within 20 cycles exp done"); end
        checks++;
        if ({ifb.fail, ifb.err_count} !== {1'b0, 2'd3}) begin errors++; $display("FAIL sat_final got fail=%b err=%0d exp 0/3", ifb.fail, ifb.err_count); end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_error_mid();
        test_error_first();
        test_abort();
        test_win1();
        test_zero_len();
        test_async_reset();
        test_saturate();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
